// File: rtl/instr_feeder.sv
// Instruction-stream initiator: steps a small loadable program buffer into the processor one word at a time.
// Optional watchdog (Err/ERR state) is compiled in when the WATCHDOG_EN macro is defined.
module instr_feeder #(
    parameter int         DATA_W  = 16,
    parameter int         ADDR_W  = 4,
    parameter logic [2:0] MVI_OPC = 3'b001,
    parameter int         TIMEOUT = 64
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Load_we,
    input  logic [ADDR_W-1:0] Load_addr,
    input  logic [DATA_W-1:0] Load_data,
    input  logic [ADDR_W:0]   Len,
    input  logic              Start,
    input  logic              Done,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Finished,
    output logic [ADDR_W-1:0] PC,
    output logic              Err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PC_W  = ADDR_W + 1;

    if (DATA_W < 9) begin : g_bad_data_w
        $error("DATA_W must be at least 9 to hold the opcode field");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_IMM   = 3'd2,
        S_WAIT  = 3'd3,
        S_END   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   len_q, len_d;
    logic              start_q;
    logic              run_q;
    logic              start_edge;
    logic              wd_trip;
    logic              busy;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] imm_addr;
    logic [DATA_W-1:0] cur_word;
    logic [PC_W-1:0]   pc_step;

    assign start_edge = Start & ~start_q;
    assign busy       = (state_q == S_ISSUE) || (state_q == S_IMM) || (state_q == S_WAIT);

    // Low ADDR_W bits address the buffer, so an mvi in the last slot wraps to word 0 for its immediate.
    assign pc_addr  = pc_q[ADDR_W-1:0];
    assign imm_addr = pc_addr + 1'b1;
    assign cur_word = mem_q[pc_addr];
    assign pc_step  = (state_q == S_IMM) ? PC_W'(2) : PC_W'(1);

    always_ff @(posedge Clock) begin
        if (Load_we && !busy) begin
            mem_q[Load_addr] <= Load_data;
        end
    end

`ifdef WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // IMM/WAIT are only ever entered from ISSUE, so the counter is already zero on entry.
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_IMM) || (state_q == S_WAIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wd_trip = ((state_q == S_IMM) || (state_q == S_WAIT)) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign Err     = (state_q == S_ERR);
`else
    assign wd_trip = 1'b0;
    assign Err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE, S_END, S_ERR: begin
                if (start_edge) begin
                    len_d   = Len;
                    pc_d    = '0;
                    state_d = (Len == '0) ? S_END : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = (cur_word[8:6] == MVI_OPC) ? S_IMM : S_WAIT;
            end
            S_IMM, S_WAIT: begin
                if (Done) begin
                    pc_d    = pc_q + pc_step;
                    state_d = (pc_d >= len_q) ? S_END : S_ISSUE;
                end else if (wd_trip) begin
                    state_d = S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Run comes straight from a flop so it cannot glitch on a multi-bit state change.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            start_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            start_q <= Start;
            run_q   <= (state_d == S_ISSUE);
        end
    end

    always_comb begin
        DIN = '0;
        case (state_q)
            S_ISSUE, S_WAIT: DIN = cur_word;
            S_IMM:           DIN = mem_q[imm_addr];
            default:         DIN = '0;
        endcase
    end

    assign Run      = run_q;
    assign Busy     = busy;
    assign Finished = (state_q == S_END);
    assign PC       = pc_addr;

endmodule
